fmap_window_linebuf: RTL and testbench
======================================

// Module: fmap_window_linebuf
// PURPOSE
//  Streaming line-buffer window generator for the conv/pool engines. Accepts one padded
//  feature-map pixel (all D channels) per handshake and presents a WIN_H x WIN_W window.
//  out_valid is asserted only at stride-aligned window positions; ready/valid backpressure
//  is supported. The block tracks frame boundaries and restarts on every frame.
// PARAMETERS
//  H         32   unpadded fmap height
//  W         128  unpadded fmap width
//  D         512  channel depth = bits per pixel
//  PAD       1    padding on each side; the input stream already contains the pad pixels
//  WIN_H     3    window height (>=1, <=H+2*PAD)
//  WIN_W     3    window width  (>=1, <=W+2*PAD)
//  STRIDE_H  1    vertical stride (>=1)
//  STRIDE_W  1    horizontal stride (>=1)
//  derived: WP=W+2*PAD, HP=H+2*PAD, DEPTH=WP*(WIN_H-1)+WIN_W, OUT_W=WIN_H*WIN_W*D
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous reset, active-low
//  in_valid    in   1      data_in carries a pixel
//  in_ready    out  1      block can accept the pixel this cycle
//  data_in     in   D      pixel, raster order, padded frame WP x HP
//  out_valid   out  1      data_out holds a valid window
//  out_ready   in   1      consumer takes the window this cycle
//  data_out    out  OUT_W  window; slice k=j+WIN_W*i at [OUT_W-1-k*D -: D] = pixel (r0+i, c0+j)
//  frame_done  out  1      one-cycle pulse: last pixel of a frame accepted
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): buffer cleared to 0, col=row=0, stride phases=0;
//    out_valid=0, frame_done=0, data_out=0. in_ready is 1 in the cycle after reset.
//  - Accept = in_valid & in_ready. in_ready = ~out_valid | out_ready (combinational).
//  - On accept: buffer shifts by one (tap 0 <= data_in, tap n <= tap n-1); col increments,
//    wraps WP-1->0 with row+1; at col=WP-1 & row=HP-1 both wrap to 0 and frame_done pulses next cycle.
//  - Window position: the accepted pixel at (row,col) completes the window with bottom-right
//    corner (row,col); r0=row-(WIN_H-1), c0=col-(WIN_W-1). Top-left pixel is tap DEPTH-1.
//  - Window valid iff row>=WIN_H-1, col>=WIN_W-1, (c0 mod STRIDE_W)==0, (r0 mod STRIDE_H)==0.
//    Moduli are tracked by phase counters (no dividers): col phase resets at col=WIN_W-1,
//    row phase resets at row=WIN_H-1, each increments and wraps at STRIDE-1.
//  - Latency: out_valid rises the cycle after the completing accept; data_out equals the
//    buffer taps and stays stable while out_valid & ~out_ready (input stalled).
//  - out_valid clears after out_valid & out_ready unless another valid window is completed
//    by an accept in the same cycle (back-to-back windows at full throughput, stride 1).
//  - Frame wrap: buffer is not cleared; stale rows are masked by the row>=WIN_H-1 rule.
//  - Windows per frame = ((HP-WIN_H)/STRIDE_H+1)*((WP-WIN_W)/STRIDE_W+1), floor division.
//  - Reset mid-frame aborts the frame; the first accept after reset is pixel (0,0).
//  - in_valid=0: state holds; out_valid/data_out unchanged until out_ready.
// STRUCTURE
//  - Shared include (includes.vh/util.vh): clog2 macro, derived-width macros WP/HP/DEPTH.
//  - Sub-module fmap_win_pos_ctr: col/row counters, stride phases, win_hit and frame_last
//    outputs. The top holds the shift register, output-valid register and handshake.
//  - Widths: col $clog2(WP), row $clog2(HP), phases $clog2(STRIDE)+1; no truncation.
// TESTING  (W=H=4, PAD=1 -> 6x6 stream, D=8, pixel value = raster index 0..35)
//  1 3x3, stride 1, in_valid=1, out_ready=1 -> 16 windows; first after pixel 14:
//    slices 0,1,2,6,7,8,12,13,14; frame_done once after pixel 35.
//  2 3x3, stride 2x2 -> 4 windows per frame, top-left pixels 0,2,12,14.
//  3 stride 1, out_ready=0 for 5 cycles at first window -> in_ready=0, data_out frozen;
//    on release no window lost or duplicated (16 total).
//  4 two frames back-to-back -> 32 windows, no window with r0<0 spanning frames, 2 frame_done pulses.
//  5 rst low after pixel 20, then full frame -> out_valid=0 during reset, 16 correct windows.
//  6 random in_valid/out_ready gaps, 2x2 window stride 2 -> 9 windows match reference model.

Source files
------------

// File: rtl/fmap_window_linebuf_pkg.sv
// Shared width helpers for the feature-map window line buffer.
// Keeps counter widths and buffer depth derived the same way in every file.
package fmap_window_linebuf_pkg;

    // Counter width that never collapses to zero bits for a one-entry range.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int phase_w(input int stride);
        return $clog2(stride) + 1;
    endfunction

    function automatic int padded(input int n, input int pad);
        return n + 2 * pad;
    endfunction

    // Taps needed so the newest pixel and the window's top-left pixel coexist.
    function automatic int line_depth(input int wp, input int win_h, input int win_w);
        return wp * (win_h - 1) + win_w;
    endfunction

endpackage

// File: rtl/fmap_window_linebuf_pos_ctr.sv
// Raster position and stride-phase tracking for the window line buffer.
// win_hit/frame_last describe the pixel that would be accepted this cycle.
module fmap_win_pos_ctr
    import fmap_window_linebuf_pkg::*;
#(
    parameter int H        = 32,
    parameter int W        = 128,
    parameter int PAD      = 1,
    parameter int WIN_H    = 3,
    parameter int WIN_W    = 3,
    parameter int STRIDE_H = 1,
    parameter int STRIDE_W = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic adv,
    output logic win_hit,
    output logic frame_last
);

    localparam int WP  = padded(W, PAD);
    localparam int HP  = padded(H, PAD);
    localparam int CW  = cnt_w(WP);
    localparam int RW  = cnt_w(HP);
    localparam int CPW = phase_w(STRIDE_W);
    localparam int RPW = phase_w(STRIDE_H);

    localparam logic [CW-1:0]  COL_LAST = CW'(WP - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(HP - 1);
    localparam logic [CW-1:0]  COL_WIN  = CW'(WIN_W - 1);
    localparam logic [RW-1:0]  ROW_WIN  = RW'(WIN_H - 1);
    localparam logic [CPW-1:0] CPH_LAST = CPW'(STRIDE_W - 1);
    localparam logic [RPW-1:0] RPH_LAST = RPW'(STRIDE_H - 1);

    logic [CW-1:0]  col, col_nx;
    logic [RW-1:0]  row, row_nx;
    logic [CPW-1:0] cph, cph_nx;
    logic [RPW-1:0] rph, rph_nx;

    always_comb begin
        col_nx = col;
        row_nx = row;
        rph_nx = rph;
        if (col == COL_LAST) begin
            col_nx = '0;
            row_nx = (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
            col_nx = col + 1'b1;
        end
        // Phase is zero exactly where the window's left/top edge is stride aligned.
        cph_nx = (col_nx == COL_WIN) ? '0 : ((cph == CPH_LAST) ? '0 : cph + 1'b1);
        if (col == COL_LAST) begin
            rph_nx = (row_nx == ROW_WIN) ? '0 : ((rph == RPH_LAST) ? '0 : rph + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
            cph <= '0;
            rph <= '0;
        end else if (adv) begin
            col <= col_nx;
            row <= row_nx;
            cph <= cph_nx;
            rph <= rph_nx;
        end
    end

    assign frame_last = (col == COL_LAST) && (row == ROW_LAST);
    assign win_hit    = (row >= ROW_WIN) && (col >= COL_WIN) && (cph == '0) && (rph == '0);

endmodule

// File: rtl/fmap_window_linebuf.sv
// Streaming WIN_H x WIN_W window generator over a padded raster feature map.
// Shift-register line buffer, registered window-valid and ready/valid handshake.
module fmap_window_linebuf
    import fmap_window_linebuf_pkg::*;
#(
    parameter int H        = 32,
    parameter int W        = 128,
    parameter int D        = 512,
    parameter int PAD      = 1,
    parameter int WIN_H    = 3,
    parameter int WIN_W    = 3,
    parameter int STRIDE_H = 1,
    parameter int STRIDE_W = 1,
    localparam int WP      = padded(W, PAD),
    localparam int DEPTH   = line_depth(WP, WIN_H, WIN_W),
    localparam int OUT_W   = WIN_H * WIN_W * D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [D-1:0]     data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             frame_done
);

    logic [D-1:0] taps_p0 [DEPTH];
    logic         vld_p1;
    logic         accept;
    logic         win_hit;
    logic         frame_last;

    assign in_ready = ~vld_p1 | out_ready;
    assign accept   = in_valid & in_ready;

    fmap_win_pos_ctr #(
        .H        (H),
        .W        (W),
        .PAD      (PAD),
        .WIN_H    (WIN_H),
        .WIN_W    (WIN_W),
        .STRIDE_H (STRIDE_H),
        .STRIDE_W (STRIDE_W)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .adv        (accept),
        .win_hit    (win_hit),
        .frame_last (frame_last)
    );

    // Stage p0: line buffer, tap 0 holds the newest accepted pixel.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int n = 0; n < DEPTH; n++) begin
                taps_p0[n] <= '0;
            end
        end else if (accept) begin
            taps_p0[0] <= data_in;
            for (int n = 1; n < DEPTH; n++) begin
                taps_p0[n] <= taps_p0[n-1];
            end
        end
    end

    // Stage p1: window valid; a new hit may overlap the consuming handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (accept && win_hit) begin
                vld_p1 <= 1'b1;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
            frame_done <= accept & frame_last;
        end
    end

    assign out_valid = vld_p1;

    // Buffer only moves on accept, so the window is frozen whenever input is stalled.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < WIN_H; i++) begin
            for (int j = 0; j < WIN_W; j++) begin
                data_out[OUT_W-1-(j+WIN_W*i)*D -: D] = taps_p0[(WIN_H-1-i)*WP + (WIN_W-1-j)];
            end
        end
    end

endmodule

// File: tb/tb_fmap_window_linebuf.sv
// Scoreboard bench: 6x6 padded stream, D=8, pixel value = base + raster index.
// Three instances cover 3x3/s1, 3x3/s2 and 2x2/s2; sel picks the one under test.
module tb_fmap_window_linebuf;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [7:0] data_in = '0;
    int sel = 0;
    int ready_mode = 0;

    always #5 clk = ~clk;

    logic        iv_a, iv_b, iv_c;
    logic        ir_a, ir_b, ir_c;
    logic        ov_a, ov_b, ov_c;
    logic        fd_a, fd_b, fd_c;
    logic [71:0] do_a, do_b;
    logic [31:0] do_c;

    assign iv_a = in_valid && (sel == 0);
    assign iv_b = in_valid && (sel == 1);
    assign iv_c = in_valid && (sel == 2);

    fmap_window_linebuf #(.H(4), .W(4), .D(8), .PAD(1), .WIN_H(3), .WIN_W(3),
                          .STRIDE_H(1), .STRIDE_W(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .data_in(data_in),
        .out_valid(ov_a), .out_ready(out_ready), .data_out(do_a), .frame_done(fd_a));

    fmap_window_linebuf #(.H(4), .W(4), .D(8), .PAD(1), .WIN_H(3), .WIN_W(3),
                          .STRIDE_H(2), .STRIDE_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .data_in(data_in),
        .out_valid(ov_b), .out_ready(out_ready), .data_out(do_b), .frame_done(fd_b));

    fmap_window_linebuf #(.H(4), .W(4), .D(8), .PAD(1), .WIN_H(2), .WIN_W(2),
                          .STRIDE_H(2), .STRIDE_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .data_in(data_in),
        .out_valid(ov_c), .out_ready(out_ready), .data_out(do_c), .frame_done(fd_c));

    logic        m_valid, m_in_ready, m_fd;
    logic [71:0] m_data;
    assign m_valid    = (sel == 0) ? ov_a : (sel == 1) ? ov_b : ov_c;
    assign m_in_ready = (sel == 0) ? ir_a : (sel == 1) ? ir_b : ir_c;
    assign m_fd       = (sel == 0) ? fd_a : (sel == 1) ? fd_b : fd_c;
    assign m_data     = (sel == 0) ? do_a : (sel == 1) ? do_b : {40'd0, do_c};

    int n_total = 0;
    int n_pass  = 0;
    int win_cnt = 0;
    int fd_cnt  = 0;
    logic [71:0] exp_q[$];
    logic [7:0]  tl_log[$];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic int cfg_win();
        return (sel == 2) ? 2 : 3;
    endfunction

    function automatic int cfg_stride();
        return (sel == 0) ? 1 : 2;
    endfunction

    function automatic bit win_ok(input int r, input int c);
        int k, s;
        k = cfg_win();
        s = cfg_stride();
        return (r >= k - 1) && (c >= k - 1) && (((r - k + 1) % s) == 0) && (((c - k + 1) % s) == 0);
    endfunction

    function automatic logic [71:0] exp_win(input int r, input int c, input int base);
        logic [71:0] v;
        int k, idx;
        v = '0;
        k = cfg_win();
        for (int i = 0; i < k; i++) begin
            for (int j = 0; j < k; j++) begin
                idx = j + k * i;
                v[k*k*8-1-idx*8 -: 8] = 8'(base + (r - k + 1 + i) * 6 + (c - k + 1 + j));
            end
        end
        return v;
    endfunction

    // Consumer side: random backpressure, or one 5-cycle stall at the first window.
    bit stall_done = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (ready_mode == 1) begin
            out_ready = 1'($urandom_range(0, 1));
        end else if (ready_mode == 2 && !stall_done && m_valid) begin
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
            stall_done = 1'b1;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: pops expected windows on each handshake, watches stalls and frame_done.
    logic [71:0] held;
    bit stalled_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (m_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_window", m_data, 72'd0);
                end else begin
                    check("window_data", m_data, exp_q.pop_front());
                end
                win_cnt++;
                tl_log.push_back((sel == 2) ? m_data[31:24] : m_data[71:64]);
            end
            if (m_valid && !out_ready) begin
                check("stall_in_ready", 72'(m_in_ready), 72'd0);
                if (stalled_prev) check("stall_data_frozen", m_data, held);
                held = m_data;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (m_fd) fd_cnt++;
        end
    end

    task automatic send_pixel(input int r, input int c, input int base, input bit gaps);
        int waited;
        bit done;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        data_in = 8'(base + r * 6 + c);
        waited = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (m_in_ready) begin
                if (win_ok(r, c)) exp_q.push_back(exp_win(r, c, base));
                done = 1'b1;
            end else if (waited >= 200) begin
                check("accept_timeout", 72'd0, 72'd1);
                done = 1'b1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit gaps);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                send_pixel(r, c, base, gaps);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, 72'(exp_q.size()), 72'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_out_valid", 72'(m_valid), 72'd0);
            check("rst_frame_done", 72'(m_fd), 72'd0);
            check("rst_data_out", m_data, 72'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 72'(m_in_ready), 72'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0, f0, tl0;
        int tl_exp[4] = '{0, 2, 12, 14};

        do_reset(2);

        // Test 1: 3x3 stride 1, full throughput
        sel = 0;
        w0 = win_cnt;
        f0 = fd_cnt;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                send_pixel(r, c, 0, 1'b0);
                if (r == 2 && c == 1) check("t1_no_early_window", 72'(m_valid), 72'd0);
                if (r == 2 && c == 2) begin
                    check("t1_first_valid", 72'(m_valid), 72'd1);
                    check("t1_first_window", m_data, 72'h000102_060708_0c0d0e);
                end
                if (r == 5 && c == 5) check("t1_frame_done", 72'(m_fd), 72'd1);
            end
        end
        @(posedge clk);
        #1;
        check("t1_frame_done_pulse", 72'(m_fd), 72'd0);
        drain("t1_drain");
        check("t1_window_count", 72'(win_cnt - w0), 72'd16);
        check("t1_frame_done_count", 72'(fd_cnt - f0), 72'd1);

        // Test 3: stall at the first window
        ready_mode = 2;
        w0 = win_cnt;
        send_frame(0, 1'b0);
        drain("t3_drain");
        ready_mode = 0;
        check("t3_window_count", 72'(win_cnt - w0), 72'd16);

        // Test 4: two frames back-to-back
        w0 = win_cnt;
        f0 = fd_cnt;
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        drain("t4_drain");
        check("t4_window_count", 72'(win_cnt - w0), 72'd32);
        check("t4_frame_done_count", 72'(fd_cnt - f0), 72'd2);

        // Test 5: reset after pixel 20, then a clean frame
        for (int p = 0; p <= 20; p++) send_pixel(p / 6, p % 6, 0, 1'b0);
        @(posedge clk);
        #1;
        check("t5_q_empty_before_rst", 72'(exp_q.size()), 72'd0);
        do_reset(2);
        w0 = win_cnt;
        send_frame(0, 1'b0);
        drain("t5_drain");
        check("t5_window_count", 72'(win_cnt - w0), 72'd16);

        // Test 2: 3x3 stride 2
        sel = 1;
        w0 = win_cnt;
        tl0 = tl_log.size();
        send_frame(0, 1'b0);
        drain("t2_drain");
        check("t2_window_count", 72'(win_cnt - w0), 72'd4);
        if (tl_log.size() >= tl0 + 4) begin
            for (int i = 0; i < 4; i++)
                check("t2_top_left", 72'(tl_log[tl0+i]), 72'(tl_exp[i]));
        end else begin
            check("t2_top_left_missing", 72'(tl_log.size() - tl0), 72'd4);
        end

        // Test 6: 2x2 stride 2 with random gaps and backpressure
        sel = 2;
        ready_mode = 1;
        w0 = win_cnt;
        send_frame(0, 1'b1);
        drain("t6_drain");
        ready_mode = 0;
        @(posedge clk);
        #1;
        check("t6_window_count", 72'(win_cnt - w0), 72'd9);
        check("end_queue_empty", 72'(exp_q.size()), 72'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
